// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT twiddle/address scheduler.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } sched_state_t;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int span_of(input int log2n, input int s);
        return (1 << log2n) >> (s + 1);
    endfunction

    function automatic int tw_shift(input int log2n, input int tw_w);
        return tw_w - log2n;
    endfunction

endpackage

// File: rtl/fft_bfly_addr.sv
// Combinational (stage, butterfly, inverse) -> (addr_a, addr_b, tw_idx) map
// for one radix-2 DIF butterfly.
module fft_bfly_addr
    import fft_sched_pkg::*;
#(
    parameter int LOG2N = 9,
    parameter int TW_W  = 9
) (
    input  logic [clog2(LOG2N)-1:0] stage,
    input  logic [LOG2N-2:0]        bfly,
    input  logic                    inverse,
    output logic [LOG2N-1:0]        addr_a,
    output logic [LOG2N-1:0]        addr_b,
    output logic [TW_W-1:0]         tw_idx
);

    localparam int TWS = tw_shift(LOG2N, TW_W);

    int s_i;
    int span;
    int pos;
    int grp;
    int base;
    int k;
    logic [TW_W-1:0] tw_fwd;

    always_comb begin
        s_i    = int'(stage);
        span   = span_of(LOG2N, s_i);
        pos    = int'(bfly) & (span - 1);
        grp    = int'(bfly) >> (LOG2N - 1 - s_i);
        base   = grp * 2 * span + pos;
        k      = pos << s_i;
        addr_a = LOG2N'(base);
        addr_b = LOG2N'(base + span);
        tw_fwd = TW_W'(k << TWS);
        // Conjugate twiddle: negate the angle around the full-circle table.
        tw_idx = inverse ? (~tw_fwd + 1'b1) : tw_fwd;
    end

endmodule

// File: rtl/fft_tw_sched.sv
// Radix-2 DIF pass sequencer: issues butterfly address pairs and twiddle indices.
// Optional FFT_TW_SCHED_BITREV_EN adds addr_rev, the bit-reversed addr_a.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | presenting butterfly commands, valid/ready handshake
// GAP   | STAGE_GAP drain cycles between stages, out_valid low
// DONE  | one-cycle done pulse, busy already low
module fft_tw_sched
    import fft_sched_pkg::*;
#(
    parameter int LOG2N     = 9,
    parameter int TW_W      = 9,
    parameter int STAGE_GAP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    inverse,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LOG2N-1:0]        addr_a,
    output logic [LOG2N-1:0]        addr_b,
    output logic [TW_W-1:0]         tw_idx,
    output logic [clog2(LOG2N)-1:0] stage,
`ifdef FFT_TW_SCHED_BITREV_EN
    output logic [LOG2N-1:0]        addr_rev,
`endif
    output logic                    stage_last
);

    localparam int SW = clog2(LOG2N);
    localparam int GW = clog2(STAGE_GAP + 1);
    localparam logic [LOG2N-2:0] B_LAST = '1;
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);

    sched_state_t      state;
    logic [SW-1:0]     cur_stage;
    logic [LOG2N-2:0]  cur_b;
    logic              inv_r;
    logic [GW-1:0]     gap_cnt;

    logic              accept;
    logic              b_end;
    logic              s_end;
    logic              load;
    logic [SW-1:0]     sel_stage;
    logic [LOG2N-2:0]  sel_b;
    logic [LOG2N-1:0]  m_addr_a;
    logic [LOG2N-1:0]  m_addr_b;
    logic [TW_W-1:0]   m_tw;

`ifdef FFT_TW_SCHED_BITREV_EN
    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
        for (int i = 0; i < LOG2N; i++) bit_rev[i] = v[LOG2N-1-i];
    endfunction
`endif

    assign accept = (state == RUN) && out_valid && out_ready;
    assign b_end  = (cur_b == B_LAST);
    assign s_end  = (cur_stage == S_LAST);

    // Select the command to register next: current one, the following
    // butterfly, or the first butterfly of the next stage.
    always_comb begin
        sel_stage = cur_stage;
        sel_b     = cur_b;
        load      = 1'b0;
        if ((accept && b_end) || state == GAP) begin
            sel_stage = cur_stage + 1'b1;
            sel_b     = '0;
        end else if (accept) begin
            sel_b = cur_b + 1'b1;
        end
        case (state)
            RUN:     load = !out_valid || (accept && !(b_end && (s_end || STAGE_GAP != 0)));
            GAP:     load = (gap_cnt == '0);
            default: load = 1'b0;
        endcase
    end

    fft_bfly_addr #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_bfly_addr (
        .stage   (sel_stage),
        .bfly    (sel_b),
        .inverse (inv_r),
        .addr_a  (m_addr_a),
        .addr_b  (m_addr_b),
        .tw_idx  (m_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_stage  <= '0;
            cur_b      <= '0;
            inv_r      <= 1'b0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            tw_idx     <= '0;
            stage      <= '0;
            stage_last <= 1'b0;
`ifdef FFT_TW_SCHED_BITREV_EN
            addr_rev   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        inv_r     <= inverse;
                        cur_stage <= '0;
                        cur_b     <= '0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (b_end && s_end) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else if (b_end && STAGE_GAP == 0) begin
                            cur_stage <= cur_stage + 1'b1;
                            cur_b     <= '0;
                        end else if (b_end) begin
                            state     <= GAP;
                            out_valid <= 1'b0;
                            gap_cnt   <= GW'(STAGE_GAP - 1);
                        end else begin
                            cur_b <= cur_b + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state     <= RUN;
                        cur_stage <= cur_stage + 1'b1;
                        cur_b     <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                out_valid  <= 1'b1;
                addr_a     <= m_addr_a;
                addr_b     <= m_addr_b;
                tw_idx     <= m_tw;
                stage      <= sel_stage;
                stage_last <= (sel_b == B_LAST);
`ifdef FFT_TW_SCHED_BITREV_EN
                addr_rev   <= bit_rev(m_addr_a);
`endif
            end
        end
    end

endmodule

// File: tb/tb_fft_tw_sched.sv
// Scoreboard bench for fft_tw_sched: an 8-point instance with stage gaps and one without.
module tb_fft_tw_sched;
    import fft_sched_pkg::*;

    localparam int LOG2N = 3;
    localparam int TW_W  = 9;
    localparam int N     = 8;
    localparam int HALF  = 4;
    localparam int SW    = clog2(LOG2N);

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [TW_W-1:0]  tw;
        logic [SW-1:0]    st;
        logic             last;
    } cmd_t;

    logic clk = 1'b0;
    logic rst, start0, start1, inverse, out_ready;
    logic bp_en = 1'b0;

    logic busy0, done0, out_valid0, stage_last0;
    logic [LOG2N-1:0] addr_a0, addr_b0;
    logic [TW_W-1:0]  tw_idx0;
    logic [SW-1:0]    stage0;
    logic busy1, done1, out_valid1, stage_last1;
    logic [LOG2N-1:0] addr_a1, addr_b1;
    logic [TW_W-1:0]  tw_idx1;
    logic [SW-1:0]    stage1;
`ifdef FFT_TW_SCHED_BITREV_EN
    logic [LOG2N-1:0] addr_rev0, addr_rev1;
`endif

    cmd_t cur0, cur1, held0, held1, e0, e1;
    cmd_t q0[$];
    cmd_t q1[$];
    assign cur0 = {addr_a0, addr_b0, tw_idx0, stage0, stage_last0};
    assign cur1 = {addr_a1, addr_b1, tw_idx1, stage1, stage_last1};

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt0 = 0, done_cnt1 = 0, acc0 = 0, acc1 = 0;
    int exp_done0 = 0, exp_done1 = 0, exp_acc0 = 0, exp_acc1 = 0;
    int run0 = 0, run1 = 0;
    bit hold0 = 0, hold1 = 0, armed0 = 0, armed1 = 0;

    fft_tw_sched #(.LOG2N(LOG2N), .TW_W(TW_W), .STAGE_GAP(4)) u_dut_gap (
        .clk(clk), .rst(rst), .start(start0), .inverse(inverse),
        .busy(busy0), .done(done0), .out_valid(out_valid0), .out_ready(out_ready),
        .addr_a(addr_a0), .addr_b(addr_b0), .tw_idx(tw_idx0), .stage(stage0),
`ifdef FFT_TW_SCHED_BITREV_EN
        .addr_rev(addr_rev0),
`endif
        .stage_last(stage_last0)
    );

    fft_tw_sched #(.LOG2N(LOG2N), .TW_W(TW_W), .STAGE_GAP(0)) u_dut_nogap (
        .clk(clk), .rst(rst), .start(start1), .inverse(inverse),
        .busy(busy1), .done(done1), .out_valid(out_valid1), .out_ready(out_ready),
        .addr_a(addr_a1), .addr_b(addr_b1), .tw_idx(tw_idx1), .stage(stage1),
`ifdef FFT_TW_SCHED_BITREV_EN
        .addr_rev(addr_rev1),
`endif
        .stage_last(stage_last1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

`ifdef FFT_TW_SCHED_BITREV_EN
    function automatic logic [LOG2N-1:0] rev3(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction
`endif

    // Reference DIF ordering: stage-major, group-major, position-minor.
    function automatic void push_frame(input bit inv);
        cmd_t c;
        int idx, span, tw;
        for (int s = 0; s < LOG2N; s++) begin
            span = N >> (s + 1);
            idx  = 0;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    tw = (p << s) << (TW_W - LOG2N);
                    if (inv) tw = (512 - tw) % 512;
                    c.a    = LOG2N'(g * 2 * span + p);
                    c.b    = LOG2N'(g * 2 * span + p + span);
                    c.tw   = TW_W'(tw);
                    c.st   = SW'(s);
                    c.last = (idx == HALF - 1);
                    idx++;
                    q0.push_back(c);
                    q1.push_back(c);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold0 = 0; armed0 = 0; run0 = 0;
        end else begin
            if (hold0) check_eq("stall_hold0", {out_valid0, cur0}, {1'b1, held0});
            if (out_valid0 && armed0) begin
                check_eq("gap_len0", run0, 4);
                armed0 = 0;
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) check_eq("unexpected_cmd0", 1, 0);
                else begin
                    e0 = q0.pop_front();
                    check_eq("cmd0", cur0, e0);
                end
                acc0++;
                hold0 = 0;
                if (stage_last0 && stage0 != SW'(LOG2N - 1)) begin
                    armed0 = 1; run0 = 0;
                end
            end else if (out_valid0) begin
                hold0 = 1; held0 = cur0;
            end else begin
                hold0 = 0;
                if (armed0) run0++;
            end
`ifdef FFT_TW_SCHED_BITREV_EN
            if (out_valid0) check_eq("addr_rev0", addr_rev0, rev3(addr_a0));
`endif
            if (done0) begin
                done_cnt0++;
                check_eq("done_busy0", busy0, 0);
                check_eq("done_qempty0", q0.size(), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold1 = 0; armed1 = 0; run1 = 0;
        end else begin
            if (hold1) check_eq("stall_hold1", {out_valid1, cur1}, {1'b1, held1});
            if (out_valid1 && armed1) begin
                check_eq("gap_len1", run1, 0);
                armed1 = 0;
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) check_eq("unexpected_cmd1", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    check_eq("cmd1", cur1, e1);
                end
                acc1++;
                hold1 = 0;
                if (stage_last1 && stage1 != SW'(LOG2N - 1)) begin
                    armed1 = 1; run1 = 0;
                end
            end else if (out_valid1) begin
                hold1 = 1; held1 = cur1;
            end else begin
                hold1 = 0;
                if (armed1) run1++;
            end
            if (done1) begin
                done_cnt1++;
                check_eq("done_busy1", busy1, 0);
                check_eq("done_qempty1", q1.size(), 0);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    task automatic launch(input bit inv);
        push_frame(inv);
        exp_done0++; exp_done1++;
        exp_acc0 += LOG2N * HALF; exp_acc1 += LOG2N * HALF;
        @(posedge clk); #1;
        start0 = 1'b1; start1 = 1'b1; inverse = inv;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        check_eq("busy_after_start", busy0, 1);
        check_eq("valid_latency1", out_valid0, 0);
        @(negedge clk);
        check_eq("valid_latency2", out_valid0, 1);
    endtask

    task automatic wait_frames();
        int cyc;
        cyc = 0;
        while ((done_cnt0 < exp_done0 || done_cnt1 < exp_done1) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("frame_timeout", cyc < 2000, 1);
        repeat (3) @(negedge clk);
        check_eq("done_count0", done_cnt0, exp_done0);
        check_eq("done_count1", done_cnt1, exp_done1);
        check_eq("bfly_count0", acc0, exp_acc0);
        check_eq("bfly_count1", acc1, exp_acc1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; inverse = 1'b0;
        #23;
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_valid", out_valid0, 0);
        check_eq("rst_last", stage_last0, 0);
        check_eq("rst_cmd", cur0, 0);
        check_eq("rst_busy1", {busy1, out_valid1, cur1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        launch(1'b0);
        wait_frames();

        launch(1'b1);
        wait_frames();

        bp_en = 1'b1;
        launch(1'b0);
        wait_frames();
        bp_en = 1'b0;

        // Restarts mid-run must not re-latch inverse.
        launch(1'b0);
        repeat (3) @(posedge clk);
        #1; start0 = 1'b1; start1 = 1'b1; inverse = 1'b1;
        @(posedge clk); #1; start0 = 1'b0; start1 = 1'b0;
        @(posedge clk); #1; start0 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0; start1 = 1'b0; inverse = 1'b0;
        check_eq("busy_during_restart", busy0 & busy1, 1);
        wait_frames();

        // Start presented during the DONE cycle is ignored.
        launch(1'b0);
        cyc = 0;
        while (!done0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("done_wait_timeout", cyc < 500, 1);
        start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        @(negedge clk);
        check_eq("done_start_busy", busy0, 0);
        repeat (3) @(negedge clk);
        check_eq("done_start_idle", {busy0, out_valid0}, 0);
        wait_frames();

        // Asynchronous reset in the middle of stage 1.
        launch(1'b0);
        cyc = 0;
        while (!(out_valid0 && stage0 == 1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("stage1_wait_timeout", cyc < 500, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", busy0, 0);
        check_eq("arst_valid", out_valid0, 0);
        check_eq("arst_cmd", cur0, 0);
        check_eq("arst_done", done0, 0);
        q0.delete(); q1.delete();
        exp_done0 = done_cnt0; exp_done1 = done_cnt1;
        repeat (4) @(negedge clk);
        check_eq("arst_no_done0", done_cnt0, exp_done0);
        check_eq("arst_no_done1", done_cnt1, exp_done1);
        exp_acc0 = acc0; exp_acc1 = acc1;
        @(posedge clk); #1;
        rst = 1'b0;
        launch(1'b0);
        wait_frames();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_tw_sched.md
Name: fft_tw_sched

Overview:
- Sequencer for one in-place radix-2 DIF FFT/IFFT pass over an N-point memory.
- Per butterfly it issues a memory address pair and the twiddle index that drives ftwiddle9/ftwiddle8 (full-circle table, 2^TW_W entries).
- Sits between the frame controller (start/done) and the butterfly datapath (valid/ready). Registered outputs; the twiddle ROM read is the consumer's responsibility.

Parameters:
- LOG2N, 9, log2 of FFT length N; legal range 3..TW_W.
- TW_W, 9, twiddle index width (9 for ftwiddle9, 8 for ftwiddle8).
- STAGE_GAP, 4, idle cycles inserted between stages for datapath drain; 0 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request.
- inverse  in  1  sampled at an accepted start; 1 = IFFT (conjugate twiddles).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last butterfly is accepted.
- out_valid  out  1  butterfly command valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- addr_a  out  LOG2N  upper butterfly leg address.
- addr_b  out  LOG2N  lower leg address, always addr_a + span.
- tw_idx  out  TW_W  twiddle index to the ftwiddle ROM.
- stage  out  clog2(LOG2N)  current stage, 0..LOG2N-1.
- stage_last  out  1  marks the last butterfly of the current stage.

Behaviour:
- Reset: FSM in IDLE. busy, done, out_valid, stage_last = 0. addr_a, addr_b, tw_idx, stage = 0.
- FSM states:
  - IDLE --start--> RUN. Latch inverse; stage = 0; butterfly counter b = 0.
  - RUN: present command; hold until accepted.
    - On accept with b = N/2-1 and stage < LOG2N-1: go to GAP (or straight to RUN at stage+1 when STAGE_GAP = 0).
    - On accept with b = N/2-1 and stage = LOG2N-1: go to DONE.
  - GAP: count STAGE_GAP cycles with out_valid = 0, then RUN with stage+1, b = 0.
  - DONE: done = 1 for one cycle; busy drops in the same cycle; next state IDLE.
- Address arithmetic for stage s, counter b:
  - span = N >> (s+1).
  - pos = b & (span-1); grp = b >> (LOG2N-1-s).
  - addr_a = grp*2*span + pos; addr_b = addr_a + span.
  - k = pos << s.
  - tw_idx = k << (TW_W-LOG2N). If inverse: tw_idx = (2^TW_W - that) mod 2^TW_W.
- Timing and handshake:
  - Outputs are registered. The first command is valid on the 2nd cycle after start is sampled.
  - With out_ready held high, there is one butterfly per cycle.
  - While out_valid && !out_ready, every output holds stable (AXI-style; valid never drops without acceptance).
- Boundary conditions:
  - start while busy: ignored; the inverse latch is unchanged.
  - start in the DONE cycle: ignored.
  - out_ready low through a stage boundary: the last butterfly holds; GAP begins only after acceptance.
  - Async reset mid-frame: immediate return to reset values; no done pulse.
- Frame length: total accepted butterflies per frame = LOG2N*N/2.

Optional Feature:
- Macro: FFT_TW_SCHED_BITREV_EN.
- When defined, adds output addr_rev (LOG2N) = bit-reverse of addr_a, registered alongside it, for a reorder buffer that consumes the final stage. addr_rev = 0 at reset.
- Without the macro, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_sched_pkg holds:
  - FSM state enum (IDLE, RUN, GAP, DONE).
  - clog2 function.
  - the span/twiddle-shift helper function.
- One natural sub-module, fft_bfly_addr: combinational mapping (stage, b, inverse) -> (addr_a, addr_b, tw_idx), instantiated before the output register.
- The FSM, counters and handshake stay in fft_tw_sched.

Test Plan:
- LOG2N=3, TW_W=9, STAGE_GAP=0, inverse=0, out_ready=1:
  - Stage 0 (a,b,tw): (0,4,0) (1,5,64) (2,6,128) (3,7,192).
  - Stage 1: (0,2,0) (1,3,128) (4,6,0) (5,7,128).
  - Stage 2: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - done pulses once, 12 butterflies total.
- Same stimulus with inverse=1 -> stage 0 tw_idx = 0, 448, 384, 320; addresses unchanged.
- STAGE_GAP=4, out_ready=1 -> exactly 4 cycles of out_valid=0 between stages; stage_last high on the 4th butterfly of each stage.
- Random out_ready backpressure (30% low) -> outputs stable while stalled; command sequence identical to the first test; done exactly once.
- start pulsed at cycles 5 and 7 of a run -> ignored; inverse latch unchanged.
- rst asserted mid-stage-1 -> same-cycle return to reset values, no done; a following start runs a full clean frame.
